// File: rtl/cfs_apb_master_pkg.sv
// Shared types and constants for the APB initiator.
//   apb_state_e    : transfer phase (IDLE, SETUP, ACCESS, RESP)
//   APB_DATA_WIDTH : fixed APB data bus width
package cfs_apb_master_pkg;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;
endpackage

// File: rtl/cfs_apb_master.sv
// APB3 initiator: turns a valid/ready request into one APB transfer and
// returns the outcome on a valid/ready response channel. One transfer is
// outstanding at a time. A wait-state counter aborts transfers whose
// ACCESS phase never completes.
//
// Ports
//   pclk, presetn             : clock, async active-low reset
//   req_valid/ready/addr/write/wdata : request channel (req_ready = IDLE)
//   rsp_valid/ready/rdata/slverr/timeout : response channel (registered)
//   paddr/pwrite/psel/penable/pwdata : APB requester outputs (registered)
//   pready/prdata/pslverr     : APB completer inputs
module cfs_apb_master
  import cfs_apb_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_write,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic                      pready,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pslverr
);

  // A zero limit still needs a legal 1-bit counter; it is never advanced.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  apb_state_e                state_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      to_hit;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic                      pwrite_q, psel_q, penable_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, rsp_rdata_q;
  logic                      rsp_valid_q, rsp_slverr_q, rsp_timeout_q;

  // Count of the wait cycle being closed now; the limit is hit when this
  // wait would be the TIMEOUT_CYCLES-th one.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    to_hit = TO_EN && (cnt_d == CNT_LIM);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // req_ready is high throughout IDLE, so req_valid alone is a handshake.
          if (req_valid) begin
            paddr_q   <= req_addr;
            pwrite_q  <= req_write;
            pwdata_q  <= req_wdata;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // Completion takes priority over a limit reached in the same cycle.
          if (pready) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_slverr_q  <= pslverr;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= pwrite_q ? '0 : prdata;
            state_q       <= ST_RESP;
          end else if (TO_EN) begin
            cnt_q <= cnt_d;
            if (to_hit) begin
              psel_q        <= 1'b0;
              penable_q     <= 1'b0;
              rsp_valid_q   <= 1'b1;
              rsp_slverr_q  <= 1'b1;
              rsp_timeout_q <= 1'b1;
              rsp_rdata_q   <= '0;
              state_q       <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_cfs_apb_master.sv
module tb_cfs_apb_master;
  localparam int AW = 16;
  localparam int TO = 4;

  logic        pclk, presetn;
  logic        req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic        pwrite, psel, penable, pready, pslverr;
  logic [31:0] pwdata, prdata;

  cfs_apb_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed slave: pready after wait_n wait states in ACCESS, never if hang.
  int   wait_n = 0;
  bit   hang = 0;
  logic [31:0] slv_rdata = '0;
  logic slv_err = 1'b0;
  int   acc_seen = 0;
  always @(negedge pclk) begin
    if (psel && penable) begin
      acc_seen++;
      pready  = (acc_seen == wait_n + 1) && !hang;
    end else begin
      acc_seen = 0;
      pready   = 1'b0;
    end
    prdata  = slv_rdata;
    pslverr = slv_err;
  end

  // Transaction-level model: tracks whether a transfer is in flight, how
  // many cycles since accept, the wait count, and the pending response.
  bit          m_busy, m_pend, m_wr, m_err, m_to;
  int          m_cyc, m_waits;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wd, m_rd;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_busy = 0; m_pend = 0; m_cyc = 0; m_waits = 0;
      m_addr = '0; m_wr = 0; m_wd = '0; m_rd = '0; m_err = 0; m_to = 0;
    end else if (m_pend) begin
      if (rsp_ready) m_pend = 0;
    end else if (m_busy) begin
      if (m_cyc == 1) m_cyc = 2;
      else if (pready) begin
        m_busy = 0; m_pend = 1; m_err = pslverr; m_to = 0;
        m_rd = m_wr ? 32'h0 : prdata;
      end else begin
        m_waits++;
        if (TO != 0 && m_waits == TO) begin
          m_busy = 0; m_pend = 1; m_err = 1; m_to = 1; m_rd = '0;
        end
      end
    end else if (req_valid) begin
      m_busy = 1; m_cyc = 1; m_waits = 0;
      m_addr = req_addr; m_wr = req_write; m_wd = req_wdata;
    end
    #1;
    chk("psel",      32'(psel),      32'(m_busy));
    chk("penable",   32'(penable),   32'(m_busy && m_cyc == 2));
    chk("req_ready", 32'(req_ready), 32'(!m_busy && !m_pend));
    chk("paddr",     32'(paddr),     32'(m_addr));
    chk("pwrite",    32'(pwrite),    32'(m_wr));
    chk("pwdata",    pwdata,         m_wd);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_pend));
    if (m_pend) begin
      chk("rsp_rdata",   rsp_rdata,         m_rd);
      chk("rsp_slverr",  32'(rsp_slverr),   32'(m_err));
      chk("rsp_timeout", 32'(rsp_timeout),  32'(m_to));
    end
  end

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  // Returns just after the accept edge (psel now visible).
  task automatic issue(input logic [AW-1:0] a, input logic w, input logic [31:0] d, input bit keep);
    @(negedge pclk);
    req_addr = a; req_write = w; req_wdata = d; req_valid = 1'b1;
    tick();
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int i;
    for (i = 0; i < 30 && !(req_ready && !rsp_valid); i++) tick();
    chk("idle_wait", 32'(req_ready && !rsp_valid), 32'd1);
  endtask

  initial begin
    presetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    #1;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_paddr", 32'(paddr), 32'd0);

    // Zero-wait write.
    wait_n = 0; slv_err = 0; slv_rdata = 32'hDEADBEEF;
    issue(16'h0000, 1'b1, 32'h00000101, 0);
    chk("w0_psel_t1", 32'(psel), 32'd1);
    chk("w0_penable_t1", 32'(penable), 32'd0);
    tick();
    chk("w0_penable_t2", 32'(penable), 32'd1);
    tick();
    chk("w0_rsp_valid_t3", 32'(rsp_valid), 32'd1);
    chk("w0_rdata", rsp_rdata, 32'h0);
    chk("w0_slverr", 32'(rsp_slverr), 32'd0);
    wait_idle();

    // Read with 3 wait states.
    wait_n = 3; slv_rdata = 32'h00030205;
    issue(16'h000c, 1'b0, 32'h0, 0);
    repeat (4) tick();
    chk("r3_psel_held", 32'(psel), 32'd1);
    chk("r3_paddr_held", 32'(paddr), 32'h000c);
    tick();
    chk("r3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("r3_rdata", rsp_rdata, 32'h00030205);
    wait_idle();

    // Slave error on a write.
    wait_n = 0; slv_err = 1;
    issue(16'h000c, 1'b1, 32'hA5A5_5A5A, 0);
    repeat (2) tick();
    chk("err_slverr", 32'(rsp_slverr), 32'd1);
    chk("err_timeout", 32'(rsp_timeout), 32'd0);
    slv_err = 0;
    wait_idle();

    // Timeout after TO wait cycles.
    hang = 1; slv_rdata = 32'h1234_5678;
    issue(16'h0040, 1'b0, 32'h0, 0);
    repeat (4) tick();
    chk("to_not_yet", 32'(rsp_valid), 32'd0);
    tick();
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_timeout", 32'(rsp_timeout), 32'd1);
    chk("to_slverr", 32'(rsp_slverr), 32'd1);
    chk("to_rdata", rsp_rdata, 32'h0);
    chk("to_psel", 32'(psel), 32'd0);
    hang = 0;
    wait_idle();

    // Response backpressure with req_valid held.
    rsp_ready = 1'b0; wait_n = 0;
    issue(16'h0008, 1'b1, 32'h0000_00ff, 1);
    repeat (2) tick();
    repeat (5) begin
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_psel", 32'(psel), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_released_psel", 32'(psel), 32'd0);
    tick();
    chk("bp_reaccept_psel", 32'(psel), 32'd1);
    req_valid = 1'b0;
    wait_idle();

    // Reset asserted during wait states.
    hang = 1;
    issue(16'h0010, 1'b0, 32'h0, 0);
    repeat (3) tick();
    chk("mr_penable_before", 32'(penable), 32'd1);
    #2 presetn = 1'b0;
    #1;
    chk("mr_psel", 32'(psel), 32'd0);
    chk("mr_penable", 32'(penable), 32'd0);
    @(negedge pclk);
    @(negedge pclk);
    hang = 0;
    presetn = 1'b1;
    #1;
    chk("mr_req_ready", 32'(req_ready), 32'd1);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
